// File: rtl/alu_add_sequencer_if.sv
// Request/response bundle for the multi-cycle wide add/subtract sequencer.
// The requester drives start/sub/a/b; the sequencer returns busy/done, result and flags.
interface alu_add_sequencer_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, negative, zero, overflow, carry_out
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, negative, zero, overflow, carry_out
  );
endinterface

// File: rtl/alu_add_sequencer.sv
// Wide add/subtract performed one SLICE-bit beat per cycle, LSB slice first,
// with the carry chained through a register and status flags captured on the last beat.
module alu_add_sequencer #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic               clk,
  input  logic               reset,
  alu_add_sequencer_if.slave bus
);
  localparam int N     = WIDTH / SLICE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] next_result;
  logic             last_beat;

  // One slice of the add per beat; next_result is the result with this beat's slice merged in,
  // so the final-beat flags see the full value before it is registered.
  always_comb begin
    slice_sum   = {1'b0, op_a[int'(idx)*SLICE +: SLICE]}
                + {1'b0, op_b[int'(idx)*SLICE +: SLICE]}
                + {{SLICE{1'b0}}, carry};
    next_result = result;
    next_result[int'(idx)*SLICE +: SLICE] = slice_sum[SLICE-1:0];
    last_beat   = (idx == IDX_W'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      result    <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_a  <= bus.a;
            op_b  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          result <= next_result;
          carry  <= slice_sum[SLICE];
          if (last_beat) begin
            carry_out <= slice_sum[SLICE];
            negative  <= next_result[WIDTH-1];
            zero      <= (next_result == '0);
            overflow  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                         (next_result[WIDTH-1] != op_a[WIDTH-1]);
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.result    = result;
  assign bus.negative  = negative;
  assign bus.zero      = zero;
  assign bus.overflow  = overflow;
  assign bus.carry_out = carry_out;
endmodule
